clk_div_multi: RTL and testbench
================================

Name: clk_div_multi

Overview:
- Multi-channel programmable clock-enable/divided-clock generator; NUM_CH independent dividers off one system clock.
- Each channel has a runtime-loadable divisor, a toggle (square wave) or pulse (one-cycle tick) mode, an enable, and glitch-free divisor update at the period boundary.
- Feeds display scan, debounce and ALU-demo timing logic on the FPGA board, replacing fixed single-rate dividers.

Parameters:
- NUM_CH, 4, number of divider channels (1..8)
- CNT_W, 32, counter and divisor width
- DEFAULT_DIV, 40000, active divisor loaded into every channel at reset

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- en  in  NUM_CH  per-channel run enable, level
- mode  in  NUM_CH  per-channel mode: 0 = toggle, 1 = pulse; sampled every cycle
- load_stb  in  1  one-cycle divisor load request
- load_ch  in  3  target channel index for load_stb
- load_val  in  CNT_W  new divisor for load_ch
- load_ack  out  1  one-cycle acknowledge, asserted the cycle after an accepted load_stb
- load_err  out  1  one-cycle error, asserted instead of load_ack when load_ch >= NUM_CH
- sync_restart  in  1  one-cycle strobe: phase-align all channels
- clk_out  out  NUM_CH  toggle-mode divided clock per channel
- tick  out  NUM_CH  pulse-mode single-cycle tick per channel
- pending  out  NUM_CH  shadow divisor waiting to be applied

Behaviour:
- Reset (rst low, async): count = 0, active_div = DEFAULT_DIV, shadow cleared, clk_out = 0, tick = 0, pending = 0, load_ack = 0, load_err = 0.
- Per-channel FSM states:
  - IDLE: en = 0; count held at 0, clk_out = 0, tick = 0.
  - RUN: en = 1, no pending load.
  - PEND: en = 1, shadow valid.
- Transitions:
  - IDLE -> RUN on en = 1. The first count increment occurs that same cycle.
  - RUN/PEND -> IDLE on en = 0. count and outputs are cleared the next cycle. A pending shadow is applied immediately on entering IDLE.
- Terminal count is count == active_div. At terminal, count goes to 0. Otherwise count increments by 1.
- Toggle mode: clk_out inverts at terminal, so the half-period is active_div+1 cycles and the full period is 2*(active_div+1). tick stays 0.
- Pulse mode: tick is high for exactly the cycle following terminal, giving period active_div+1. clk_out stays 0.
- active_div = 0:
  - Toggle mode gives clk/2.
  - Pulse mode holds tick continuously high.
- Mode change mid-run: takes effect at the next terminal. The outgoing output is forced to 0 at that point.
- Load, valid channel:
  - Channel in IDLE: active_div = load_val next cycle.
  - Channel in RUN: shadow = load_val, pending = 1, state -> PEND.
  - PEND at terminal: active_div = shadow, pending = 0, -> RUN. The current period always completes at the old divisor.
- Load to a channel already in PEND overwrites the shadow; it is still applied at the same terminal.
- Load when load_ch >= NUM_CH: ignored, load_err pulses.
- Load coinciding with the terminal of a PEND channel: the terminal applies the old shadow, and the new value becomes the shadow (pending stays 1).
- sync_restart:
  - Every channel sets count = 0, clk_out = 0, tick = 0.
  - Pending shadows are applied immediately.
  - Enabled channels resume counting from 0 in the next cycle, so phases are aligned.
  - If sync_restart and load_stb arrive in the same cycle, the load is processed after the restart: the loaded value goes directly to active_div.
- Count never exceeds active_div. If active_div is reduced below count by a load in IDLE or by sync_restart, count is already 0, so no wrap-through to 2^CNT_W occurs.

Decomposition:
- Shared include/package holds MODE_TOGGLE = 0, MODE_PULSE = 1, the FSM state encodings (IDLE/RUN/PEND, 2 bits) and the DEFAULT_DIV default.
- One sub-module, clk_div_channel: counter, FSM, shadow register and outputs for one channel.
- The top instantiates NUM_CH channels via generate and decodes load_stb/load_ch into per-channel load strobes and ack/err.

Test Plan:
- Reset, then en[0] = 1, mode = 0 with DEFAULT_DIV = 40000 -> first clk_out[0] rise after 40001 cycles; period 80002 cycles.
- Load ch1 = 3 while idle, en[1] = 1, mode = 1 -> load_ack 1 cycle after strobe; tick[1] high 1 cycle every 4 cycles.
- Ch2 running at div 9, load 4 mid-period -> pending[2] = 1, current half-period still 10 cycles, following half-periods 5 cycles, pending clears at terminal.
- load_ch = 5 with NUM_CH = 4 -> load_err 1 cycle, no ack, no channel state change.
- Ch0 div 2 and ch1 div 6 running, sync_restart pulse -> both counts 0, outputs 0; ch0 clk_out rises after 3 cycles, ch1 after 7 cycles.
- rst low mid-run with pending set -> all outputs 0 asynchronously; after release active_div = 40000, pending = 0.

Source files
------------

// File: rtl/clk_div_multi_pkg.sv
// Shared definitions for the multi-channel clock divider: output modes,
// per-channel FSM encoding and the reset-time divisor.
package clk_div_multi_pkg;

  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

  localparam int unsigned DIV_RESET_DEFAULT = 40000;
  localparam int unsigned CH_IDX_W          = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } ch_state_e;

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, run/pending FSM, shadow divisor, outputs.
//   clk, rst          system clock, async active-low reset
//   en, mode          run enable; 0 = toggle, 1 = pulse
//   load, load_val    channel-local divisor load strobe and value
//   sync_restart      phase-align strobe shared by all channels
//   clk_out, tick     toggle-mode square wave / pulse-mode tick
//   pending           shadow divisor waiting for the period boundary
module clk_div_channel
  import clk_div_multi_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned DEFAULT_DIV = DIV_RESET_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             sync_restart,
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             clk_out_d, tick_d;
  logic             term_c;

  assign term_c = (count_q == div_q);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state: a restart or a dropped enable always lands in a clean state;
  // a restart that coincides with a load takes the load directly, so no PEND.
  always_comb begin
    state_d = state_q;
    if (sync_restart) begin
      state_d = en ? ST_RUN : ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (en) state_d = ST_RUN;
        ST_RUN: begin
          if (!en)       state_d = ST_IDLE;
          else if (load) state_d = ST_PEND;
        end
        ST_PEND: begin
          if (!en)                 state_d = ST_IDLE;
          else if (term_c && !load) state_d = ST_RUN;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Counter, divisor and output next values
  always_comb begin
    count_d   = count_q;
    div_d     = div_q;
    shadow_d  = shadow_q;
    clk_out_d = clk_out;
    tick_d    = tick;
    if (sync_restart || !en) begin
      // Cleared channel: apply any waiting shadow now, a fresh load wins over it
      count_d   = '0;
      clk_out_d = 1'b0;
      tick_d    = 1'b0;
      if (state_q == ST_PEND) div_d = shadow_q;
      if (load)               div_d = load_val;
    end else begin
      // Terminal check uses the divisor in force this cycle, even on an IDLE load
      if (term_c) begin
        count_d = '0;
        if (mode == MODE_PULSE) begin
          tick_d    = 1'b1;
          clk_out_d = 1'b0;
        end else begin
          tick_d    = 1'b0;
          clk_out_d = ~clk_out;
        end
        if (state_q == ST_PEND) div_d = shadow_q;
      end else begin
        count_d = count_q + CNT_W'(1);
        tick_d  = 1'b0;
      end
      if (load) begin
        if (state_q == ST_IDLE) div_d    = load_val;
        else                    shadow_d = load_val;
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q  <= '0;
      div_q    <= CNT_W'(DEFAULT_DIV);
      shadow_q <= '0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
      pending  <= 1'b0;
    end else begin
      count_q  <= count_d;
      div_q    <= div_d;
      shadow_q <= shadow_d;
      clk_out  <= clk_out_d;
      tick     <= tick_d;
      pending  <= (state_d == ST_PEND);
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider / clock-enable generator.
//   clk, rst                     system clock, async active-low reset
//   en, mode [NUM_CH]            per-channel enable and mode (0 toggle, 1 pulse)
//   load_stb, load_ch, load_val  divisor load request
//   load_ack, load_err           one-cycle response the cycle after load_stb
//   sync_restart                 phase-align all channels
//   clk_out, tick, pending       per-channel outputs
module clk_div_multi
  import clk_div_multi_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned DEFAULT_DIV = DIV_RESET_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_CH-1:0]   en,
  input  logic [NUM_CH-1:0]   mode,
  input  logic                load_stb,
  input  logic [CH_IDX_W-1:0] load_ch,
  input  logic [CNT_W-1:0]    load_val,
  output logic                load_ack,
  output logic                load_err,
  input  logic                sync_restart,
  output logic [NUM_CH-1:0]   clk_out,
  output logic [NUM_CH-1:0]   tick,
  output logic [NUM_CH-1:0]   pending
);

  logic [NUM_CH-1:0] ch_load_c;
  logic              ch_valid_c;

  // Extra bit so NUM_CH = 8 still compares correctly
  assign ch_valid_c = ({1'b0, load_ch} < (CH_IDX_W + 1)'(NUM_CH));

  // Load response, one cycle after the strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_ack <= 1'b0;
      load_err <= 1'b0;
    end else begin
      load_ack <= load_stb && ch_valid_c;
      load_err <= load_stb && !ch_valid_c;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ch_load_c[i] = load_stb && (load_ch == CH_IDX_W'(i));

    clk_div_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .en           (en[i]),
      .mode         (mode[i]),
      .load         (ch_load_c[i]),
      .load_val     (load_val),
      .sync_restart (sync_restart),
      .clk_out      (clk_out[i]),
      .tick         (tick[i]),
      .pending      (pending[i])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Randomised scoreboard bench for clk_div_multi against a per-cycle reference model.
module tb_clk_div_multi;

  localparam int unsigned NUM_CH  = 4;
  localparam int unsigned CNT_W   = 32;
  localparam int unsigned DEF_DIV = 100;

  logic                clk;
  logic                rst;
  logic [NUM_CH-1:0]   en, mode;
  logic                load_stb;
  logic [2:0]          load_ch;
  logic [CNT_W-1:0]    load_val;
  logic                sync_restart;
  logic                load_ack, load_err;
  logic [NUM_CH-1:0]   clk_out, tick, pending;

  clk_div_multi #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEF_DIV)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .mode         (mode),
    .load_stb     (load_stb),
    .load_ch      (load_ch),
    .load_val     (load_val),
    .load_ack     (load_ack),
    .load_err     (load_err),
    .sync_restart (sync_restart),
    .clk_out      (clk_out),
    .tick         (tick),
    .pending      (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] pending;
    logic              ack;
    logic              err;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: what each channel is doing, in the spec's own terms
  logic [CNT_W-1:0]  m_cnt [NUM_CH];
  logic [CNT_W-1:0]  m_div [NUM_CH];
  logic [CNT_W-1:0]  m_sh  [NUM_CH];
  bit                m_pend[NUM_CH];
  bit                m_clk [NUM_CH];
  bit                m_tick[NUM_CH];
  bit                m_run [NUM_CH];
  logic [NUM_CH-1:0] en_v, mode_v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_cnt[c] = '0; m_div[c] = CNT_W'(DEF_DIV); m_sh[c] = '0;
      m_pend[c] = 0; m_clk[c] = 0; m_tick[c] = 0; m_run[c] = 0;
    end
  endtask

  // Advance the model by one clock edge with the given inputs
  function automatic exp_t model_step(input bit ls, input int lc, input logic [CNT_W-1:0] lv, input bit sr);
    exp_t e;
    e = '0;
    e.ack = ls && (lc < int'(NUM_CH));
    e.err = ls && (lc >= int'(NUM_CH));
    for (int c = 0; c < NUM_CH; c++) begin
      bit ld;
      ld = ls && (lc == c);
      if (sr || !en_v[c]) begin
        if (m_pend[c]) m_div[c] = m_sh[c];
        m_pend[c] = 0;
        if (ld) m_div[c] = lv;
        m_cnt[c] = '0; m_clk[c] = 0; m_tick[c] = 0;
      end else begin
        if (m_cnt[c] == m_div[c]) begin
          m_cnt[c] = '0;
          if (mode_v[c]) begin m_tick[c] = 1; m_clk[c] = 0; end
          else begin m_clk[c] = !m_clk[c]; m_tick[c] = 0; end
          if (m_pend[c]) begin m_div[c] = m_sh[c]; m_pend[c] = 0; end
        end else begin
          m_cnt[c] = m_cnt[c] + 1;
          m_tick[c] = 0;
        end
        if (ld) begin
          if (m_run[c]) begin m_sh[c] = lv; m_pend[c] = 1; end
          else m_div[c] = lv;
        end
      end
      m_run[c]     = en_v[c];
      e.clk_out[c] = m_clk[c];
      e.tick[c]    = m_tick[c];
      e.pending[c] = m_pend[c];
    end
    return e;
  endfunction

  task automatic drive(input bit ls = 1'b0, input int lc = 0, input int unsigned lv = 0, input bit sr = 1'b0);
    @(negedge clk);
    en = en_v; mode = mode_v;
    load_stb = ls; load_ch = 3'(lc); load_val = CNT_W'(lv); sync_restart = sr;
    exp_q.push_back(model_step(ls, lc, CNT_W'(lv), sr));
  endtask

  task automatic run(input int n);
    repeat (n) drive();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_clk_out"}, 32'(clk_out), 32'(0));
    check({tag, "_tick"},    32'(tick),    32'(0));
    check({tag, "_pending"}, 32'(pending), 32'(0));
    check({tag, "_ack"},     32'(load_ack), 32'(0));
    check({tag, "_err"},     32'(load_err), 32'(0));
  endtask

  task automatic quiet_inputs();
    en = '0; mode = '0; en_v = '0; mode_v = '0;
    load_stb = 0; load_ch = '0; load_val = '0; sync_restart = 0;
  endtask

  // Monitor: every cycle the DUT presents outputs, compare with the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("clk_out", 32'(clk_out), 32'(e.clk_out));
        check("tick",    32'(tick),    32'(e.tick));
        check("pending", 32'(pending), 32'(e.pending));
        check("ack",     32'(load_ack), 32'(e.ack));
        check("err",     32'(load_err), 32'(e.err));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int idx;
    bit ls, sr;
    int lc;
    int unsigned lv;

    quiet_inputs();
    model_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    #2 check_reset_outputs("por");
    @(negedge clk) rst = 1'b1;

    // ch0 toggle at the reset divisor: rise after DEF_DIV+1 cycles, period 2*(DEF_DIV+1)
    en_v[0] = 1;
    run(2 * (DEF_DIV + 1) + 10);

    // ch1 loaded while idle, then pulse mode: tick every 4 cycles
    drive(1, 1, 3);
    en_v[1] = 1; mode_v[1] = 1;
    run(20);

    // ch2 at div 9, load 4 mid-period: current half-period keeps the old divisor
    drive(1, 2, 9);
    en_v[2] = 1;
    run(14);
    drive(1, 2, 4);
    run(40);

    // Out-of-range channel loads
    drive(1, 5, 7);
    drive(1, 4, 2);
    run(3);

    // Reload ch0/ch1 while running (pending), then restart to apply and align
    drive(1, 0, 2);
    drive(1, 1, 6);
    mode_v[1] = 0;
    run(2);
    drive(0, 0, 0, 1);
    run(30);

    // Restart coinciding with a load, then disable a channel holding a pending load
    drive(1, 3, 5, 1);
    en_v[3] = 1;
    run(15);
    drive(1, 3, 1);
    en_v[3] = 0;
    run(3);
    en_v[3] = 1;
    run(12);

    // Divisor zero in both modes, then a mid-run mode change
    drive(1, 1, 0);
    run(8);
    mode_v[1] = 1;
    run(10);
    mode_v[2] = 1;
    run(20);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        idx = int'($urandom_range(0, NUM_CH - 1));
        en_v[idx] = ~en_v[idx];
      end
      if ($urandom_range(0, 39) == 0) begin
        idx = int'($urandom_range(0, NUM_CH - 1));
        mode_v[idx] = ~mode_v[idx];
      end
      ls = ($urandom_range(0, 7) == 0);
      lc = int'($urandom_range(0, 5));
      lv = $urandom_range(0, 12);
      sr = ($urandom_range(0, 99) == 0);
      drive(ls, lc, lv, sr);
    end

    // Reset in the middle of a run with a load pending on ch3
    en_v = '1; mode_v = '0;
    drive(1, 3, 10, 1);
    run(4);
    drive(1, 3, 3);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check_reset_outputs("async_rst");
    quiet_inputs();
    model_reset();
    @(negedge clk) rst = 1'b1;

    // After release the reset divisor is back in force
    en_v[0] = 1;
    run(2 * (DEF_DIV + 1) + 5);
    en_v = '0;
    run(2);

    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
